// File: rtl/field_pkg.sv
// rtl/field_pkg.sv - shared constants, pow state encoding and bit-scan helper for the field arithmetic layer
package field_pkg;

    localparam int F_NBITS = 61;
    localparam logic [F_NBITS-1:0] F_PRIME = {F_NBITS{1'b1}};
    localparam int F_IDXW = $clog2(F_NBITS);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } pow_state_t;

    // Index of the most significant set bit; 0 when v is zero.
    function automatic logic [F_IDXW-1:0] msb_index(input logic [F_NBITS-1:0] v);
        msb_index = '0;
        for (int j = 0; j < F_NBITS; j++) begin
            if (v[j]) msb_index = F_IDXW'(j);
        end
    endfunction

endpackage

// File: rtl/field_multiplier.sv
// rtl/field_multiplier.sv - two-stage modular multiplier over the Mersenne prime 2^nbits-1
module field_multiplier
    import field_pkg::*;
#(
    parameter int nbits = F_NBITS
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic [nbits-1:0] a,
    input  logic [nbits-1:0] b,
    output logic             ready_pulse,
    output logic             ready,
    output logic [nbits-1:0] c
);

    logic                 s1;
    logic [2*nbits-1:0]   prod;
    logic [nbits:0]       fold1;
    logic [nbits-1:0]     fold2;

    // 2^nbits == 1 mod p, so the high half folds onto the low half; two folds
    // leave a value in [0, p], and p itself maps to 0.
    always_comb begin
        fold1 = {1'b0, prod[nbits-1:0]} + {1'b0, prod[2*nbits-1:nbits]};
        fold2 = fold1[nbits-1:0] + {{(nbits-1){1'b0}}, fold1[nbits]};
    end

    assign ready = !s1;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            s1          <= 1'b0;
            prod        <= '0;
            ready_pulse <= 1'b0;
            c           <= '0;
        end else begin
            ready_pulse <= s1;
            s1          <= en && ready;
            if (en && ready) begin
                prod <= (2*nbits)'(a) * (2*nbits)'(b);
            end
            if (s1) begin
                c <= (fold2 == nbits'(F_PRIME)) ? '0 : fold2;
            end
        end
    end

endmodule

// File: rtl/field_pow.sv
// rtl/field_pow.sv - left-to-right square-and-multiply exponentiation c = a^e mod p
module field_pow
    import field_pkg::*;
#(
    parameter int nbits = F_NBITS
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic [nbits-1:0] a,
    input  logic [nbits-1:0] e,
    output logic             ready_pulse,
    output logic             ready,
    output logic [nbits-1:0] c
);

    pow_state_t         state, state_d;
    logic [nbits-1:0]   acc, acc_d, base, base_d, e_q, e_d, c_d;
    logic [F_IDXW-1:0]  i_q, i_d;
    logic               sq_q, sq_d;

    logic               mul_en, mul_rp, mul_ready;
    logic [nbits-1:0]   mul_b, mul_c;

    assign mul_b = sq_q ? acc : base;

    field_multiplier #(.nbits(nbits)) u_mul (
        .clk         (clk),
        .rstb        (rstb),
        .en          (mul_en),
        .a           (acc),
        .b           (mul_b),
        .ready_pulse (mul_rp),
        .ready       (mul_ready),
        .c           (mul_c)
    );

    always_comb begin
        state_d     = state;
        acc_d       = acc;
        base_d      = base;
        e_d         = e_q;
        i_d         = i_q;
        sq_d        = sq_q;
        c_d         = c;
        mul_en      = 1'b0;
        ready       = (state == IDLE) || (state == DONE);
        ready_pulse = (state == DONE);

        case (state)
            ISSUE: begin
                mul_en = mul_ready;
                if (mul_ready) state_d = WAIT;
            end
            WAIT: begin
                if (mul_rp) begin
                    acc_d = mul_c;
                    if (sq_q && e_q[i_q]) begin
                        sq_d    = 1'b0;
                        state_d = ISSUE;
                    end else if (i_q == '0) begin
                        state_d = DONE;
                    end else begin
                        i_d     = i_q - F_IDXW'(1);
                        sq_d    = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase

        // The leading 1 of e is consumed by loading acc with a, so e<=1 needs no multiplies.
        if (ready && en) begin
            base_d  = a;
            e_d     = e;
            sq_d    = 1'b1;
            i_d     = msb_index(F_NBITS'(e)) - F_IDXW'(1);
            acc_d   = (e == '0) ? nbits'(1) : a;
            state_d = (e[nbits-1:1] == '0) ? DONE : ISSUE;
        end

        if (state_d == DONE) c_d = acc_d;
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state <= IDLE;
            acc   <= '0;
            base  <= '0;
            e_q   <= '0;
            i_q   <= '0;
            sq_q  <= 1'b0;
            c     <= '0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            base  <= base_d;
            e_q   <= e_d;
            i_q   <= i_d;
            sq_q  <= sq_d;
            c     <= c_d;
        end
    end

endmodule
